// File: rtl/lru_way_alloc_ctrl_if.sv
// ---------------------------------------------------------------------------
// lru_way_alloc_ctrl_if
// Bundles the request, response and LRU-tracker signals of the 8-way set
// allocation controller.
//   master : controller view (drives req_ready, rsp_*, lru_access_*)
//   slave  : environment view (requester, response sink and LRU tracker)
// Signals:
//   req_valid/req_ready/req_tag/req_inval  lookup or invalidate request
//   rsp_valid/rsp_ready/rsp_hit/rsp_way/rsp_evict/rsp_evict_tag  response
//   lru_access_valid/lru_access_way        access pulse to the LRU tracker
//   lru_evict_way                          tracker's least-recently-used way
// ---------------------------------------------------------------------------
interface lru_way_alloc_ctrl_if #(
  parameter int TAG_W = 12
);
  logic             req_valid;
  logic             req_ready;
  logic [TAG_W-1:0] req_tag;
  logic             req_inval;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_hit;
  logic [2:0]       rsp_way;
  logic             rsp_evict;
  logic [TAG_W-1:0] rsp_evict_tag;
  logic             lru_access_valid;
  logic [2:0]       lru_access_way;
  logic [2:0]       lru_evict_way;

  modport master (
    input  req_valid, req_tag, req_inval, rsp_ready, lru_evict_way,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag,
           lru_access_valid, lru_access_way
  );

  modport slave (
    output req_valid, req_tag, req_inval, rsp_ready, lru_evict_way,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag,
           lru_access_valid, lru_access_way
  );
endinterface

// File: rtl/lru_way_alloc_ctrl.sv
// ---------------------------------------------------------------------------
// lru_way_alloc_ctrl
// Tag lookup and way allocation for a single 8-way set. Requests are looked
// up against 8 valid/tag entries; read hits and fills each send one access
// pulse to the external LRU tracker, invalidates clear the matching line,
// and fills into a full set take the tracker's evict way as the victim.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset, drops any transaction in flight
//   bus    : lru_way_alloc_ctrl_if.master (request, response, LRU tracker)
// ---------------------------------------------------------------------------
module lru_way_alloc_ctrl #(
  parameter int TAG_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lru_way_alloc_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_ALLOC,
    S_RESP
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [7:0]             r_valid;
  logic [7:0][TAG_W-1:0]  r_tag;
  logic [TAG_W-1:0]       r_capTag;
  logic                   r_capInval;
  logic [2:0]             r_victim;
  logic                   r_rspHit;
  logic [2:0]             r_rspWay;
  logic                   r_rspEvict;
  logic [TAG_W-1:0]       r_rspEvictTag;

  logic [7:0]             w_match;
  logic                   w_hit;
  logic [2:0]             w_hitWay;
  logic                   w_full;
  logic [2:0]             w_freeWay;
  logic                   w_lruValid;
  logic [2:0]             w_lruWay;

  // Tag compare and the two lowest-index priority encoders (hit way and
  // first free way); scanning downward lets the lowest index win.
  always_comb begin
    w_match   = '0;
    w_hitWay  = '0;
    w_freeWay = '0;
    for (int i = 0; i < 8; i++) begin
      w_match[i] = r_valid[i] && (r_tag[i] == r_capTag);
    end
    for (int i = 7; i >= 0; i--) begin
      if (w_match[i]) w_hitWay = 3'(i);
      if (!r_valid[i]) w_freeWay = 3'(i);
    end
  end

  assign w_hit  = |w_match;
  assign w_full = &r_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state decode plus the LRU access pulse, which is combinational so
  // that an asynchronous reset in LOOKUP/ALLOC suppresses it immediately.
  always_comb begin
    w_nextState = r_state;
    w_lruValid  = 1'b0;
    w_lruWay    = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) w_nextState = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit && !r_capInval) begin
          w_lruValid = 1'b1;
          w_lruWay   = w_hitWay;
        end
        if (!w_hit && !r_capInval) w_nextState = S_ALLOC;
        else                       w_nextState = S_RESP;
      end
      S_ALLOC: begin
        w_lruValid  = 1'b1;
        w_lruWay    = r_victim;
        w_nextState = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Valid bits, captured request and response fields. The evict way is only
  // read in LOOKUP and held in r_victim, so the tracker may move on during
  // ALLOC without disturbing the fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= '0;
      r_capTag      <= '0;
      r_capInval    <= 1'b0;
      r_victim      <= '0;
      r_rspHit      <= 1'b0;
      r_rspWay      <= '0;
      r_rspEvict    <= 1'b0;
      r_rspEvictTag <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_capTag   <= bus.req_tag;
            r_capInval <= bus.req_inval;
          end
        end
        S_LOOKUP: begin
          r_rspEvict    <= 1'b0;
          r_rspEvictTag <= '0;
          if (w_hit) begin
            r_rspHit <= 1'b1;
            r_rspWay <= w_hitWay;
            if (r_capInval) r_valid[w_hitWay] <= 1'b0;
          end else if (r_capInval) begin
            r_rspHit <= 1'b0;
            r_rspWay <= '0;
          end else if (!w_full) begin
            r_rspHit <= 1'b0;
            r_victim <= w_freeWay;
          end else begin
            r_rspHit      <= 1'b0;
            r_victim      <= bus.lru_evict_way;
            r_rspEvict    <= 1'b1;
            r_rspEvictTag <= r_tag[bus.lru_evict_way];
          end
        end
        S_ALLOC: begin
          r_valid[r_victim] <= 1'b1;
          r_rspHit          <= 1'b0;
          r_rspWay          <= r_victim;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rspEvict    <= 1'b0;
            r_rspEvictTag <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag array has no reset; entries are meaningless until their valid bit
  // is set by a fill.
  always_ff @(posedge clk) begin
    if (r_state == S_ALLOC) r_tag[r_victim] <= r_capTag;
  end

  assign bus.req_ready        = (r_state == S_IDLE);
  assign bus.rsp_valid        = (r_state == S_RESP);
  assign bus.rsp_hit          = r_rspHit;
  assign bus.rsp_way          = r_rspWay;
  assign bus.rsp_evict        = r_rspEvict;
  assign bus.rsp_evict_tag    = r_rspEvictTag;
  assign bus.lru_access_valid = w_lruValid;
  assign bus.lru_access_way   = w_lruWay;

endmodule

// File: doc/lru_way_alloc_ctrl.md
Name: lru_way_alloc_ctrl

Overview:
- Single-set tag lookup and way-allocation controller for the 8-way L1 set. It is the initiator side of the LRU-tracker interface.
- It accepts lookup/invalidate requests and compares them against 8 stored tags with valid bits.
- On every hit or fill it drives one access pulse into the LRU tracker.
- On a miss with the set full, it consumes the tracker's evict way and reports the victim tag to the line-fill/writeback logic.

Parameters:
- TAG_W, 12, tag width in bits; legal range 1..32.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_tag  in  TAG_W  tag to look up.
- req_inval  in  1  1 = invalidate the matching line; 0 = read/fill access.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  downstream accepts the response.
- rsp_hit  out  1  tag matched a valid way.
- rsp_way  out  3  way hit, filled, or invalidated.
- rsp_evict  out  1  fill displaced a valid line.
- rsp_evict_tag  out  TAG_W  tag of the displaced line; 0 when rsp_evict=0.
- lru_access_valid  out  1  one-cycle access pulse to the LRU tracker.
- lru_access_way  out  3  way accessed; 0 when lru_access_valid=0.
- lru_evict_way  in  3  tracker's current least-recently-used way.

Behaviour:
- Storage: valid[7:0] and tag[7:0][TAG_W-1:0]. rst_n low clears valid to 0; tag contents are don't-care.
- FSM states: IDLE, LOOKUP, ALLOC, RESP. Reset state is IDLE.
- Reset values:
  - rsp_valid, rsp_hit, rsp_way, rsp_evict, rsp_evict_tag = 0.
  - lru_access_valid, lru_access_way = 0.
  - req_ready = 1 (decoded from IDLE).
- IDLE: req_ready=1. On req_valid && req_ready, capture req_tag and req_inval, then go to LOOKUP. req_ready=0 in every other state.
- LOOKUP, exactly 1 cycle. Match vector = valid[i] && tag[i]==captured tag. At most one bit can be set; if several are, the lowest index wins.
  - Hit, inval=0: lru_access_valid=1, lru_access_way=hit way in this cycle; latch rsp_hit=1, rsp_way=hit way; go to RESP.
  - Hit, inval=1: clear valid[hit way]; no LRU access; latch rsp_hit=1, rsp_way=hit way; go to RESP.
  - Miss, inval=1: no state change; latch rsp_hit=0, rsp_way=0; go to RESP.
  - Miss, inval=0: choose a victim and go to ALLOC.
    - If any way is invalid, the victim is the lowest-index invalid way, and rsp_evict=0.
    - Otherwise, sample lru_evict_way in this cycle as the victim; rsp_evict=1 and rsp_evict_tag=tag[victim].
- ALLOC, 1 cycle:
  - Write tag[victim]=captured tag and set valid[victim]=1.
  - Pulse lru_access_valid with lru_access_way=victim.
  - Latch rsp_hit=0, rsp_way=victim; go to RESP.
- RESP:
  - rsp_valid=1. All rsp_* fields are stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_ready, go to IDLE. rsp_valid drops in the next cycle and rsp_evict/rsp_evict_tag clear to 0.
- Latency, measured from the accept edge (cycle N):
  - Hit or invalidate: rsp_valid is high in cycle N+2.
  - Fill: rsp_valid is high in cycle N+3.
  - Back-to-back: a new request can be accepted the cycle after the rsp handshake.
- LRU interface rules:
  - At most one lru_access_valid pulse per request; exactly one for read-hit and fill, none for invalidate.
  - lru_evict_way is sampled only in LOOKUP and is never re-read in ALLOC.
- Boundary conditions:
  - rsp_ready already high on the first RESP cycle: the response completes in 1 cycle.
  - req_valid while req_ready=0: ignored, not captured.
  - Invalidating the same tag twice: the second returns a miss.
  - Fill after an invalidate reuses the freed way (lowest invalid), even if the LRU tracker points elsewhere.
  - rst_n asserted mid-transaction: the transaction is dropped, no response or LRU pulse is emitted, the FSM goes to IDLE, and all valid bits clear.

Test Plan:
- Reset, then fill tags 0x100..0x107 in order -> rsp_hit=0, rsp_way=0..7, rsp_evict=0; each is preceded by one lru_access pulse to ways 0..7; fill latency 3.
- With the set full, read tag 0x103 -> rsp_hit=1, rsp_way=3, rsp_valid in cycle N+2, a single lru_access_way=3 pulse, no tag change.
- With the set full, tracker model driving lru_evict_way=5, miss on 0x2AA -> rsp_evict=1, rsp_evict_tag=0x105, rsp_way=5, lru pulse on way 5; a subsequent read of 0x2AA hits way 5.
- Invalidate 0x102 -> rsp_hit=1, rsp_way=2, no lru pulse. Invalidate 0x102 again -> rsp_hit=0. Then miss on 0x3CC -> fills way 2 with rsp_evict=0, regardless of lru_evict_way.
- Hold rsp_ready=0 for 4 cycles with req_valid=1 -> rsp fields stable, req_ready=0, the second request is not accepted until the handshake completes.
- Assert rst_n low during ALLOC of a fill -> no rsp_valid and no lru pulse; after release, req_ready=1 and every tag misses.
